// File: rtl/cache_pkg.sv
// Shared types and widths for the cache memory-side responder and its storage.
package cache_pkg;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 5;
  localparam int CNT_W      = 4;
  localparam int WB_COUNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    READ,
    WRITE,
    RESP
  } rsp_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wb;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
  } mem_req_t;

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port backing store: synchronous write, combinational read, powers up as mem[i] = i.
module mem_array_1rw #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Words are stored XOR-ed with their own address: the two-state array starts
  // all-zero, which therefore reads back as the required identity image.
  bit   [DATA_W-1:0] store [DEPTH];
  logic [DATA_W-1:0] addr_key;

  assign addr_key = DATA_W'(addr);

  // NOTE: the storage array has no reset; contents must survive a responder reset.
  always_ff @(posedge clock) begin
    if (we) begin
      store[addr] <= wdata ^ addr_key;
    end
  end

  assign rdata = store[addr] ^ addr_key;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: refill reads, write-throughs and victim write-backs with
// a programmable per-phase latency, all over one request/response handshake.
module cache_mem_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int DATA_W  = cache_pkg::DATA_W,
  parameter int LATENCY = 2                  // edges per memory phase, 1..15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic [7:0]        wb_count
);

  localparam logic [CNT_W-1:0]      CNT_RELOAD   = CNT_W'(LATENCY - 1);
  localparam logic [WB_COUNT_W-1:0] WB_COUNT_MAX = '1;

  rsp_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  mem_req_t              req_q, req_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  write_q, write_d;
  logic                  valid_q, valid_d;
  logic [WB_COUNT_W-1:0] wb_count_q, wb_count_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cnt_done;

  assign cnt_done = (cnt_q == '0);

  mem_array_1rw #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // NOTE: state lives only in this block and uses non-blocking assignments;
  // all next-state decisions are made combinationally below.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      valid_q    <= 1'b0;
      wb_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      write_q    <= write_d;
      valid_q    <= valid_d;
      wb_count_q <= wb_count_d;
    end
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    write_d    = write_q;
    valid_d    = valid_q;
    wb_count_d = wb_count_q;
    mem_we     = 1'b0;
    mem_addr   = req_q.addr;
    mem_wdata  = req_q.wdata;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = '{write:   req_write,
                    addr:    req_addr,
                    wdata:   req_wdata,
                    wb:      req_wb,
                    wb_addr: wb_addr,
                    wb_data: wb_data};
          cnt_d = CNT_RELOAD;
          if (req_write)   state_d = WRITE;
          else if (req_wb) state_d = WB;
          else             state_d = READ;
        end
      end

      WB: begin
        mem_addr  = req_q.wb_addr;
        mem_wdata = req_q.wb_data;
        if (!cnt_done) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_we = 1'b1;
          if (wb_count_q != WB_COUNT_MAX) wb_count_d = wb_count_q + WB_COUNT_W'(1);
          cnt_d   = CNT_RELOAD;
          state_d = READ;
        end
      end

      READ: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rdata_d = mem_rdata;
          write_d = 1'b0;
          valid_d = 1'b1;
          state_d = RESP;
        end
      end

      WRITE: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_we  = 1'b1;
          rdata_d = req_q.wdata;
          write_d = 1'b1;
          valid_d = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_write = write_q;
  assign wb_count  = wb_count_q;

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the 2-way cache: services refill reads, write-throughs and dirty-victim write-backs issued by the cache controller.
- Owns the 32 x 5-bit backing store, so all memory traffic crosses one valid/ready request and response handshake.
- Models a configurable access latency so cache miss and write-back timing can be exercised on the bench and on the board.

Parameters:
- ADDR_W, 5, address width (backing store has 2**ADDR_W words)
- DATA_W, 5, block width
- LATENCY, 2, clock edges per memory phase; legal range 1..15

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_write  in  1  0 = read/refill, 1 = write req_wdata
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data (req_write=1)
- req_wb  in  1  read only: write back the victim before the read
- wb_addr  in  ADDR_W  victim address
- wb_data  in  DATA_W  victim block
- rsp_valid  out  1  response available; held until accepted
- rsp_ready  in  1  cache accepts response
- rsp_rdata  out  DATA_W  read data, or echoed write data
- rsp_write  out  1  echo of the captured req_write
- wb_count  out  8  number of completed write-backs, saturating at 255

Behaviour:
- Reset (async, active-high), applied immediately:
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_write = 0; wb_count = 0; latency counter = 0.
  - Backing-store contents are NOT affected by reset. They are initialised once at time zero to mem[i] = i mod 32.
  - Reset mid-operation abandons the transaction. A write or write-back whose final edge has not yet occurred leaves memory unchanged.
- States:
  - IDLE: req_ready = 1. On an edge with req_valid=1, capture all request fields (accept edge T); cnt <= LATENCY-1.
    - req_write=1 -> WRITE
    - req_write=0 and req_wb=1 -> WB
    - otherwise -> READ
    - req_wb is ignored when req_write=1.
  - WB: on each edge with cnt != 0, decrement cnt. On the edge with cnt == 0: mem[wb_addr] <= wb_data; wb_count increments (saturating); cnt <= LATENCY-1; go to READ.
  - READ: on the edge with cnt == 0: rsp_rdata <= mem[req_addr], rsp_write <= 0, rsp_valid <= 1; go to RESP.
  - WRITE: on the edge with cnt == 0: mem[req_addr] <= req_wdata, rsp_rdata <= req_wdata, rsp_write <= 1, rsp_valid <= 1; go to RESP.
  - RESP: rsp_valid and rsp_rdata stay stable. On an edge with rsp_ready=1: rsp_valid <= 0; go to IDLE.
- Latency from accept edge T:
  - READ and WRITE: response visible after edge T+LATENCY.
  - Write-back read: response visible after edge T+2*LATENCY.
  - New request acceptance: earliest edge is the one after the response handshake.
- Ordering:
  - The write-back always completes before the read. If wb_addr == req_addr, the read returns wb_data.
  - Read-after-write to the same address returns the newly written data.
- Request handling:
  - Inputs are sampled only at the accept edge; later changes to req_* and wb_* are ignored.
  - req_valid is ignored outside IDLE; there is no queueing.
- rsp_ready may be held high permanently, giving a one-cycle rsp_valid pulse.
- Address arithmetic is modulo 2**ADDR_W; no out-of-range condition exists.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W, DATA_W constants
  - responder state enum {IDLE, WB, READ, WRITE, RESP}
  - request struct {write, addr, wdata, wb, wb_addr, wb_data}
- One natural sub-module: mem_array_1rw, the single-port synchronous-write, combinational-read storage with time-zero init mem[i] = i. This keeps the FSM/latency logic separate from storage.

Test Plan:
- Reset, then read addr 5 with LATENCY=2 and rsp_ready=1 -> rsp_valid high exactly 2 edges after accept; rsp_rdata=5; rsp_write=0; req_ready low until the handshake.
- Write addr 9 data 21, then read addr 9 -> first response rsp_rdata=21 with rsp_write=1; second response rsp_rdata=21.
- Read addr 3 with req_wb=1, wb_addr=3, wb_data=30 -> response after 4 edges with rsp_rdata=30; wb_count=1.
- Read addr 7 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata=7 stay stable; a req_valid pulse during this time is not accepted; handshake then returns to IDLE.
- Assert reset during the WB phase of (wb_addr=12, wb_data=0) -> outputs return to reset values immediately; a later read of addr 12 returns 12; wb_count=0.
- Issue 256 write-back reads -> wb_count saturates at 255; LATENCY=1 run shows single-cycle phases.
